reg_dump_reader: RTL

- Sequential reader for the 32x32 CPU register file: on request, walks the registers in index order and streams each (index, value) pair out over a valid/ready interface.
- Drives the register file's asynchronous read port (address out, data back in the same cycle) and captures each value into an output holding register.
- Sits beside the register file, outside the datapath. Used by halt-time dump, debug and testbench checkers.
- Never writes the register file.

---
 rtl/reg_dump_reader.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_dump_reader.sv
// Sequential register-file dump engine: walks registers 0..NUM_REGS-1 through the
// asynchronous read port and streams (index, value) pairs over valid/ready.
module reg_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_dout,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done,
  output logic [5:0]  sent_count
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [4:0]  dump_idx_nx;
  logic [31:0] dump_data_nx;
  logic [5:0]  sent_count_nx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dump_idx   <= '0;
      dump_data  <= '0;
      sent_count <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      dump_idx   <= dump_idx_nx;
      dump_data  <= dump_data_nx;
      sent_count <= sent_count_nx;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    dump_idx_nx   = dump_idx;
    dump_data_nx  = dump_data;
    sent_count_nx = sent_count;

    if (abort) begin
      // Cancel leaves the captured entry and the count visible for inspection.
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx_nx        = '0;
            sent_count_nx = '0;
            state_nx      = READ;
          end
        end
        READ: begin
          dump_data_nx = rf_dout;
          dump_idx_nx  = idx;
          if (SKIP_ZERO && (rf_dout == '0)) begin
            if (idx == LAST_IDX) state_nx = DONE;
            else                 idx_nx   = idx + 5'd1;
          end else begin
            state_nx = SEND;
          end
        end
        SEND: begin
          if (dump_ready) begin
            sent_count_nx = sent_count + 6'd1;
            // Terminal compare comes before the increment so idx never wraps.
            if (idx == LAST_IDX) begin
              state_nx = DONE;
            end else begin
              idx_nx   = idx + 5'd1;
              state_nx = READ;
            end
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign rf_addr    = idx;
  assign dump_valid = (state == SEND);
  assign busy       = (state == READ) || (state == SEND);
  assign done       = (state == DONE);

endmodule
